sha256_msg_scheduler: RTL and testbench

Reader side of the 512-bit block store. It loads one stored 512-bit message block and emits the 64 SHA-256 schedule words W0..W63, one per transfer, to the round datapath. The block uses a 16-word sliding window and computes W16..W63 on the fly, so the full 64-word schedule is never held.

---
 rtl/sha256_msg_scheduler_if.sv | 31 +++
 rtl/sha256_msg_scheduler.sv | 95 +++++++++
 tb/tb_sha256_msg_scheduler.sv | 226 ++++++++++++++++++++++
 3 files changed

// File: rtl/sha256_msg_scheduler_if.sv
// Handshake/bus bundle between the block store reader and the SHA-256 round datapath.
// w_ready exists only when SCHED_BACKPRESSURE_EN is defined.
interface sha256_msg_scheduler_if;
  logic         start;
  logic [511:0] block_in;
  logic [31:0]  w_out;
  logic [5:0]   w_idx;
  logic         w_valid;
  logic         w_last;
  logic         busy;
  logic         done;
`ifdef SCHED_BACKPRESSURE_EN
  logic         w_ready;
`endif

  modport master (
`ifdef SCHED_BACKPRESSURE_EN
    output w_ready,
`endif
    output start, block_in,
    input  w_out, w_idx, w_valid, w_last, busy, done
  );

  modport slave (
`ifdef SCHED_BACKPRESSURE_EN
    input  w_ready,
`endif
    input  start, block_in,
    output w_out, w_idx, w_valid, w_last, busy, done
  );
endinterface

// File: rtl/sha256_msg_scheduler.sv
// SHA-256 message scheduler: 16-word sliding window emitting W0..W63 one per transfer.
// Optional SCHED_BACKPRESSURE_EN adds a w_ready handshake from the round datapath.
module sha256_msg_scheduler #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input logic                  CLK,
  input logic                  RST,
  sha256_msg_scheduler_if.slave bus
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_RUN   = 1'b1;
  localparam logic [5:0] LAST_IDX = 6'(ROUNDS - 1);

  logic [0:0]        state_reg;
  logic [5:0]        idx_reg;
  logic              done_reg;
  logic [WORD_W-1:0] w_reg  [16];
  logic [WORD_W-1:0] w_next [16];
  logic [WORD_W-1:0] w_new;
  logic              w_ready;
  logic              accept;
  logic              xfer;

  function automatic logic [31:0] sigma0(input logic [31:0] x);
    return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
  endfunction

  function automatic logic [31:0] sigma1(input logic [31:0] x);
    return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
  endfunction

`ifdef SCHED_BACKPRESSURE_EN
  assign w_ready = bus.w_ready;
`else
  assign w_ready = 1'b1;
`endif

  assign accept = (state_reg == ST_IDLE) && bus.start;
  assign xfer   = (state_reg == ST_RUN) && w_ready;

  // Next schedule word enters at the tail as the head word is consumed.
  assign w_new = sigma1(w_reg[14]) + w_reg[9] + sigma0(w_reg[1]) + w_reg[0];

  generate
    for (genvar gi = 0; gi < 16; gi++) begin : g_window
      if (gi < 15) begin : g_shift
        assign w_next[gi] = accept ? bus.block_in[16*WORD_W-1-WORD_W*gi -: WORD_W]
                          : xfer   ? w_reg[gi+1]
                          :          w_reg[gi];
      end else begin : g_tail
        assign w_next[gi] = accept ? bus.block_in[WORD_W-1:0]
                          : xfer   ? w_new
                          :          w_reg[gi];
      end

      always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
          w_reg[gi] <= '0;
        end else begin
          w_reg[gi] <= w_next[gi];
        end
      end
    end
  endgenerate

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_reg <= ST_IDLE;
      idx_reg   <= '0;
      done_reg  <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (accept) begin
        state_reg <= ST_RUN;
        idx_reg   <= '0;
      end else if (xfer) begin
        idx_reg <= idx_reg + 6'd1;
        if (idx_reg == LAST_IDX) begin
          state_reg <= ST_IDLE;
          done_reg  <= 1'b1;
        end
      end
    end
  end

  assign bus.w_out   = w_reg[0];
  assign bus.w_idx   = idx_reg;
  assign bus.w_valid = (state_reg == ST_RUN);
  assign bus.busy    = (state_reg == ST_RUN);
  assign bus.w_last  = (state_reg == ST_RUN) && (idx_reg == LAST_IDX);
  assign bus.done    = done_reg;

endmodule

// File: tb/tb_sha256_msg_scheduler.sv
// Scoreboard bench for sha256_msg_scheduler: stimulus pushes expected words, a monitor pops them.
module tb_sha256_msg_scheduler;
  logic CLK = 1'b0;
  logic RST = 1'b0;
  logic tb_ready = 1'b1;

  always #5 CLK = ~CLK;

  sha256_msg_scheduler_if bus ();
  sha256_msg_scheduler #(.WORD_W(32), .ROUNDS(64)) dut (.CLK(CLK), .RST(RST), .bus(bus));

`ifdef SCHED_BACKPRESSURE_EN
  assign bus.w_ready = tb_ready;
  initial begin
    forever begin
      @(posedge CLK);
      #1 tb_ready = 1'($urandom_range(0, 1));
    end
  end
`endif

  typedef struct {
    logic [5:0]  idx;
    logic [31:0] w;
    logic        last;
  } exp_t;

  exp_t sb_q[$];
  int   checks   = 0;
  int   failures = 0;

  function automatic void check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=0x%0h required=0x%0h", name, act, req);
    end
  endfunction

  // Golden model: textbook recurrence over the full 64-entry schedule.
  function automatic logic [31:0] ss0(input logic [31:0] x);
    return ((x >> 7) | (x << 25)) ^ ((x >> 18) | (x << 14)) ^ (x >> 3);
  endfunction
  function automatic logic [31:0] ss1(input logic [31:0] x);
    return ((x >> 17) | (x << 15)) ^ ((x >> 19) | (x << 13)) ^ (x >> 10);
  endfunction

  function automatic void push_block(input logic [511:0] blk);
    logic [31:0] wm [64];
    exp_t e;
    for (int t = 0; t < 16; t++) wm[t] = blk[511-32*t -: 32];
    for (int t = 16; t < 64; t++) wm[t] = ss1(wm[t-2]) + wm[t-7] + ss0(wm[t-15]) + wm[t-16];
    for (int t = 0; t < 64; t++) begin
      e.idx  = 6'(t);
      e.w    = wm[t];
      e.last = (t == 63);
      sb_q.push_back(e);
    end
  endfunction

  // Monitor: pops one expectation per observed transfer, checks hold and done timing.
  exp_t        mon_e;
  logic        last_xfer_prev = 1'b0;
  logic        hold_pending   = 1'b0;
  logic [31:0] held_w;
  logic [5:0]  held_idx;
  logic        held_last;

  always @(negedge CLK) begin
    if (!RST) begin
      last_xfer_prev = 1'b0;
      hold_pending   = 1'b0;
    end else begin
      check("done_timing", 64'(bus.done), 64'(last_xfer_prev));
      check("busy_vs_valid", 64'(bus.busy), 64'(bus.w_valid));
      if (hold_pending) begin
        check("hold_valid", 64'(bus.w_valid), 64'(1'b1));
        check("hold_w_out", 64'(bus.w_out), 64'(held_w));
        check("hold_w_idx", 64'(bus.w_idx), 64'(held_idx));
        check("hold_w_last", 64'(bus.w_last), 64'(held_last));
      end
      last_xfer_prev = 1'b0;
      hold_pending   = 1'b0;
      if (bus.w_valid) begin
        if (tb_ready) begin
          if (sb_q.size() == 0) begin
            check("unexpected_word", 64'(bus.w_idx), 64'hFFFF_FFFF_FFFF_FFFF);
          end else begin
            mon_e = sb_q.pop_front();
            check("w_out", 64'(bus.w_out), 64'(mon_e.w));
            check("w_idx", 64'(bus.w_idx), 64'(mon_e.idx));
            check("w_last", 64'(bus.w_last), 64'(mon_e.last));
            $display("xfer idx=%0d w_out=%08h exp=%08h last=%0b", bus.w_idx, bus.w_out, mon_e.w, bus.w_last);
            last_xfer_prev = mon_e.last;
          end
        end else begin
          hold_pending = 1'b1;
          held_w       = bus.w_out;
          held_idx     = bus.w_idx;
          held_last    = bus.w_last;
        end
      end
    end
  end

  task automatic start_block(input logic [511:0] blk);
    push_block(blk);
    bus.start    = 1'b1;
    bus.block_in = blk;
    @(negedge CLK);
    bus.start    = 1'b0;
    bus.block_in = {16{32'hBAD0_F00D}};
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    while (n < limit) begin
      @(negedge CLK);
      n++;
      if (bus.done) return;
    end
    check("done_timeout", 64'(n), 64'(0));
  endtask

  task automatic wait_idx(input logic [5:0] target, input int limit);
    for (int i = 0; i < limit; i++) begin
      if (bus.w_valid && bus.w_idx == target) return;
      @(negedge CLK);
    end
    check("idx_timeout", 64'(bus.w_idx), 64'(target));
  endtask

  localparam logic [511:0] BLK_ABC  = {32'h6162_6380, 448'd0, 32'h0000_0018};
  localparam logic [511:0] BLK_ZERO = 512'd0;
  localparam logic [511:0] BLK_A    = {8{64'h0123_4567_89AB_CDEF}};
  localparam logic [511:0] BLK_B    = {16{32'hA5A5_F00F}};
  localparam logic [511:0] BLK_C    = {8{64'hFEDC_BA98_7654_3210}};
  localparam logic [511:0] BLK_D    = {4{128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF}};

  initial begin
    int n;
    int base;
    bus.start    = 1'b0;
    bus.block_in = '0;

    repeat (3) @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    check("rst_w_valid", 64'(bus.w_valid), 64'(1'b0));
    check("rst_busy", 64'(bus.busy), 64'(1'b0));
    check("rst_done", 64'(bus.done), 64'(1'b0));
    check("rst_w_out", 64'(bus.w_out), 64'(32'd0));
    check("rst_w_idx", 64'(bus.w_idx), 64'(6'd0));

    // "abc" block with hand-computed words replacing the model at 0, 15, 16, 17.
    base = sb_q.size();
    push_block(BLK_ABC);
    sb_q[base+0].w  = 32'h6162_6380;
    sb_q[base+15].w = 32'h0000_0018;
    sb_q[base+16].w = 32'h6162_6380;
    sb_q[base+17].w = 32'h000F_0000;
    bus.start    = 1'b1;
    bus.block_in = BLK_ABC;
    @(negedge CLK);
    bus.start    = 1'b0;
    bus.block_in = '0;
    wait_done(2000, n);
`ifndef SCHED_BACKPRESSURE_EN
    check("abc_done_latency", 64'(n + 1), 64'(65));
`endif
    $display("block abc done after %0d cycles", n + 1);

    // All-zero block, then back-to-back start in the done cycle.
    start_block(BLK_ZERO);
    wait_done(2000, n);
    $display("block zero done");
    start_block(BLK_A);
    check("b2b_valid", 64'(bus.w_valid), 64'(1'b1));
    check("b2b_idx", 64'(bus.w_idx), 64'(6'd0));
    wait_done(2000, n);
    $display("block A done");

    // start during RUN with different data must be ignored.
    start_block(BLK_C);
    wait_idx(6'd10, 2000);
    bus.start    = 1'b1;
    bus.block_in = BLK_B;
    @(negedge CLK);
    bus.start    = 1'b0;
    wait_done(2000, n);
    $display("block C with ignored start done");

    // Reset mid-block aborts immediately with no done pulse.
    start_block(BLK_B);
    wait_idx(6'd30, 2000);
    #2 RST = 1'b0;
    #1;
    check("abort_w_valid", 64'(bus.w_valid), 64'(1'b0));
    check("abort_busy", 64'(bus.busy), 64'(1'b0));
    check("abort_w_out", 64'(bus.w_out), 64'(32'd0));
    check("abort_w_idx", 64'(bus.w_idx), 64'(6'd0));
    check("abort_w_last", 64'(bus.w_last), 64'(1'b0));
    check("abort_done", 64'(bus.done), 64'(1'b0));
    sb_q.delete();
    repeat (3) @(negedge CLK);
    RST = 1'b1;
    repeat (3) @(negedge CLK);
    check("abort_idle_valid", 64'(bus.w_valid), 64'(1'b0));
    start_block(BLK_D);
    check("post_abort_w0", 64'(bus.w_out), 64'(32'h0011_2233));
    wait_done(2000, n);
    $display("block D after abort done");

    repeat (2) @(negedge CLK);
    check("queue_drained", 64'(sb_q.size()), 64'(0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
